uart_tx: RTL

//   8N1 UART transmitter, the serialising end of the board UART link. Takes a

---
 rtl/uart_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 (or 8E1 with UART_TX_PARITY_EN) UART transmitter.
// Bit period is 2*CLK_PER_HALF_BIT clocks; txd is registered, idle high.
module uart_tx #(
  parameter int CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sdata,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       txd
);

  localparam int BitCyc = 2 * CLK_PER_HALF_BIT;
  localparam int CW = $clog2(BitCyc + 1);
  localparam logic [CW-1:0] LastCnt = CW'(BitCyc - 1);

  typedef enum logic [3:0] {
    s_idle,
    s_start_bit,
    s_bit_0,
    s_bit_1,
    s_bit_2,
    s_bit_3,
    s_bit_4,
    s_bit_5,
    s_bit_6,
    s_bit_7,
`ifdef UART_TX_PARITY_EN
    s_parity,
`endif
    s_stop_bit
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] data_q, data_n;
  logic txd_n;

  // State, bit timer, latched byte and line register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= s_idle;
      cnt    <= '0;
      data_q <= '0;
      txd    <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      data_q <= data_n;
      txd    <= txd_n;
    end
  end

  // Next state: accept in idle, else advance once per bit period.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = data_q;
    if (state == s_idle) begin
      cnt_n = '0;
      if (tx_start) begin
        state_n = s_start_bit;
        data_n  = sdata;
      end
    end else if (cnt == LastCnt) begin
      cnt_n = '0;
      unique case (state)
        s_start_bit: state_n = s_bit_0;
        s_bit_0:     state_n = s_bit_1;
        s_bit_1:     state_n = s_bit_2;
        s_bit_2:     state_n = s_bit_3;
        s_bit_3:     state_n = s_bit_4;
        s_bit_4:     state_n = s_bit_5;
        s_bit_5:     state_n = s_bit_6;
        s_bit_6:     state_n = s_bit_7;
`ifdef UART_TX_PARITY_EN
        s_bit_7:     state_n = s_parity;
        s_parity:    state_n = s_stop_bit;
`else
        s_bit_7:     state_n = s_stop_bit;
`endif
        s_stop_bit:  state_n = s_idle;
        default:     state_n = s_idle;
      endcase
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end

  // Line value for the state being entered, so txd stays registered.
  always_comb begin
    txd_n = 1'b1;
    unique case (state_n)
      s_start_bit: txd_n = 1'b0;
      s_bit_0:     txd_n = data_n[0];
      s_bit_1:     txd_n = data_n[1];
      s_bit_2:     txd_n = data_n[2];
      s_bit_3:     txd_n = data_n[3];
      s_bit_4:     txd_n = data_n[4];
      s_bit_5:     txd_n = data_n[5];
      s_bit_6:     txd_n = data_n[6];
      s_bit_7:     txd_n = data_n[7];
`ifdef UART_TX_PARITY_EN
      s_parity:    txd_n = ^data_n;
`endif
      default:     txd_n = 1'b1;
    endcase
  end

  assign tx_busy = (state != s_idle);

endmodule
